shift_seq_ctrl: RTL and testbench

//  Sequencer for a multi-cycle 16-bit shift/rotate unit with one shared datapath stage.

---
 rtl/shift_seq_ctrl_pkg.sv | 24 ++
 rtl/shift_seq_ctrl_stage.sv | 41 ++++
 rtl/shift_seq_ctrl.sv | 118 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
//   Shared types and constants for the sequenced 16-bit shift/rotate unit:
//   operation codes, controller state codes, datapath width and level count.
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

   localparam int WIDTH  = 16;
   localparam int NLEVEL = 4;

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//   One combinational shift/rotate level. The amount is 1, 2, 4 or 8 as
//   selected by lvl; op chooses rotate vs. zero-fill and the direction.
// Ports
//   din   [15:0]  operand
//   lvl   [1:0]   level index, amount = 1 << lvl
//   op    op_e    ROL / SLL / ROR / SRL
//   dout  [15:0]  result
// ---------------------------------------------------------------------------
module shift_stage
   import shift_seq_ctrl_pkg::*;
(
   input  logic [WIDTH-1:0] din,
   input  logic [1:0]       lvl,
   input  op_e              op,
   output logic [WIDTH-1:0] dout
);

   logic [4:0] amt_s;
   logic [4:0] inv_s;

   // amount and its complement; inv_s is the shift that brings the wrapped bits around
   always_comb begin
      amt_s = 5'd1 << lvl;
      inv_s = 5'd16 - amt_s;
   end

   // apply the selected operation for this level
   always_comb begin
      dout = din;
      case (op)
         OP_ROL:  dout = (din << amt_s) | (din >> inv_s);
         OP_SLL:  dout = din << amt_s;
         OP_ROR:  dout = (din >> amt_s) | (din << inv_s);
         OP_SRL:  dout = din >> amt_s;
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequencer for a multi-cycle 16-bit shift/rotate. A request is latched in
//   IDLE, then levels 1,2,4,8 are applied one per cycle through a single
//   shared stage (always four SHIFT cycles), and the result is offered with
//   a valid/ready handshake in DONE.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_data [15:0]       operand
//   req_cnt  [3:0]        shift amount 0..15
//   req_op   [1:0]        00 ROL, 01 SLL, 10 ROR, 11 SRL
//   resp_valid/resp_ready response handshake
//   resp_data [15:0]      result, stable while resp_valid is high
//   busy                  high while in SHIFT
// ---------------------------------------------------------------------------
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [3:0]       req_cnt,
   input  logic [1:0]       req_op,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             busy
);

   state_e           state_r;
   logic [1:0]       lvl_r;
   logic [WIDTH-1:0] acc_r;
   logic [3:0]       cnt_r;
   op_e              op_r;
   logic [WIDTH-1:0] stage_s;

   shift_stage u_stage (
      .din  (acc_r),
      .lvl  (lvl_r),
      .op   (op_r),
      .dout (stage_s)
   );

   // controller FSM with level counter, operand registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         lvl_r      <= 2'd0;
         acc_r      <= 16'h0000;
         cnt_r      <= 4'h0;
         op_r       <= OP_ROL;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= 16'h0000;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  acc_r     <= req_data;
                  cnt_r     <= req_cnt;
                  op_r      <= op_e'(req_op);
                  lvl_r     <= 2'd0;
                  state_r   <= ST_SHIFT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
               resp_valid <= 1'b0;
            end
            ST_SHIFT: begin
               if (cnt_r[lvl_r]) begin
                  acc_r <= stage_s;
               end else begin
                  acc_r <= acc_r;
               end
               lvl_r <= lvl_r + 2'd1;
               if (lvl_r == 2'd3) begin
                  // the level-8 update lands in acc_r at this same edge, so
                  // the response must take the stage output directly
                  resp_data  <= cnt_r[3] ? stage_s : acc_r;
                  resp_valid <= 1'b1;
                  busy       <= 1'b0;
                  state_r    <= ST_DONE;
               end else begin
                  busy <= 1'b1;
               end
               req_ready <= 1'b0;
            end
            ST_DONE: begin
               // req_ready rises only after the response has been taken
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state_r    <= ST_IDLE;
               end else begin
                  resp_valid <= 1'b1;
                  req_ready  <= 1'b0;
               end
               busy <= 1'b0;
            end
            default: begin
               state_r    <= ST_IDLE;
               lvl_r      <= 2'd0;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Directed self-checking bench for shift_seq_ctrl with hand-computed
//   expected results.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_data;
   logic [3:0]  req_cnt;
   logic [1:0]  req_op;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   shift_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_cnt    (req_cnt),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // issue one request with resp_ready high and check the full 6-cycle timeline
   task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] c,
                         input logic [1:0] o, input logic [15:0] exp);
      int guard;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check({tag, "_ready_wait"}, {15'd0, req_ready}, 16'h0001);
      req_valid = 1'b1; req_data = d; req_cnt = c; req_op = o;
      tick();                                    // accept edge N
      req_valid = 1'b0; req_data = 16'hDEAD; req_cnt = 4'hF; req_op = 2'b11;
      check({tag, "_busy"}, {15'd0, busy}, 16'h0001);
      check({tag, "_rdy_low"}, {15'd0, req_ready}, 16'h0000);
      for (int i = 1; i < 4; i++) begin
         tick();
         check({tag, "_early_valid"}, {15'd0, resp_valid}, 16'h0000);
      end
      tick();                                    // edge N+4
      check({tag, "_valid"}, {15'd0, resp_valid}, 16'h0001);
      check({tag, "_data"}, resp_data, exp);
      check({tag, "_busy_done"}, {15'd0, busy}, 16'h0000);
      tick();                                    // edge N+5, response taken
      check({tag, "_valid_drop"}, {15'd0, resp_valid}, 16'h0000);
      check({tag, "_rdy_back"}, {15'd0, req_ready}, 16'h0001);
   endtask

   initial begin
      logic [15:0] held;
      rst = 1'b1; req_valid = 1'b0; req_data = 16'h0000; req_cnt = 4'h0;
      req_op = 2'b00; resp_ready = 1'b1;

      // 1. reset
      tick(); tick();
      rst = 1'b0;
      check("rst_req_ready", {15'd0, req_ready}, 16'h0001);
      check("rst_resp_valid", {15'd0, resp_valid}, 16'h0000);
      check("rst_busy", {15'd0, busy}, 16'h0000);
      check("rst_resp_data", resp_data, 16'h0000);

      // 2..4. functional cases
      run_op("rol1",   16'h8001, 4'd1,  2'b00, 16'h0003);
      run_op("srl4",   16'hF00F, 4'd4,  2'b11, 16'h0F00);
      run_op("ror4",   16'hF00F, 4'd4,  2'b10, 16'hFF00);
      run_op("sll15",  16'hF00F, 4'd15, 2'b01, 16'h8000);
      run_op("ror0",   16'h1234, 4'd0,  2'b10, 16'h1234);
      run_op("rol15",  16'h1234, 4'd15, 2'b00, 16'h091A);

      // 5. back-pressure in DONE
      resp_ready = 1'b0;
      req_valid = 1'b1; req_data = 16'h00F0; req_cnt = 4'd2; req_op = 2'b01;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("bp_valid", {15'd0, resp_valid}, 16'h0001);
      check("bp_data", resp_data, 16'h03C0);
      held = resp_data;
      for (int i = 0; i < 5; i++) begin
         req_valid = i[0] ? 1'b0 : 1'b1;
         req_data = 16'hAAAA; req_cnt = 4'd7; req_op = 2'b10;
         tick();
         check("bp_hold_valid", {15'd0, resp_valid}, 16'h0001);
         check("bp_hold_data", resp_data, held);
         check("bp_hold_rdy", {15'd0, req_ready}, 16'h0000);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      tick();
      check("bp_taken_valid", {15'd0, resp_valid}, 16'h0000);
      check("bp_taken_rdy", {15'd0, req_ready}, 16'h0001);
      tick();
      check("bp_no_restart", {15'd0, busy}, 16'h0000);

      // 6. reset in the second SHIFT cycle
      req_valid = 1'b1; req_data = 16'hF00F; req_cnt = 4'd4; req_op = 2'b01;
      tick();                                    // accept
      req_valid = 1'b0;
      tick();                                    // now in 2nd SHIFT cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_rdy", {15'd0, req_ready}, 16'h0001);
      check("mid_rst_busy", {15'd0, busy}, 16'h0000);
      check("mid_rst_valid", {15'd0, resp_valid}, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mid_rst_no_resp", {15'd0, resp_valid}, 16'h0000);
      end
      run_op("sll3", 16'h0001, 4'd3, 2'b01, 16'h0008);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
